// File: rtl/ctrl_pkg.sv
// Shared types and field helpers for the systolic-array instruction sequencer.
package ctrl_pkg;

    typedef enum logic [4:0] {
        OP_NONE      = 5'h00,
        OP_MAC       = 5'h01,
        OP_SEND_WT   = 5'h02,
        OP_STORE_OUT = 5'h03,
        OP_RECV_INP  = 5'h04,
        OP_RECV_WT   = 5'h05,
        OP_TX_OUT    = 5'h06,
        OP_ACC_RST   = 5'h07,
        OP_NOP       = 5'h1F
    } opcode_e;

    localparam logic [1:0] SS_IDLE   = 2'b00;
    localparam logic [1:0] SS_WE     = 2'b01;
    localparam logic [1:0] SS_STREAM = 2'b10;

    localparam int OPC_W = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } fsm_state_e;

    function automatic int addr_lsb();
        return OPC_W;
    endfunction

    function automatic int data_lsb(input int addr_w);
        return OPC_W + addr_w;
    endfunction

    function automatic int entry_w(input int addr_w, input int data_w);
        return OPC_W + addr_w + data_w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with combinational head read and wrap-bit full/empty detection.
module instr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Queues instructions and decodes them into registered buffer/accumulator/MAC command pulses,
// holding multi-cycle streaming commands for their programmed length.
module instr_sequencer
    import ctrl_pkg::*;
#(
    parameter int INSTR_W            = 64,
    parameter int ADDR_W             = 14,
    parameter int DATA_W             = 32,
    parameter int OUT_ADDR_W         = 4,
    parameter int FIFO_DEPTH         = 4,
    parameter int CNT_W              = 8,
    parameter int DEFAULT_STREAM_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    output logic [ADDR_W-1:0]     inp_buf_addr,
    output logic [DATA_W-1:0]     inp_buf_data,
    output logic [ADDR_W-1:0]     wt_buf_addr,
    output logic [DATA_W-1:0]     wt_buf_data,
    output logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr,
    output logic                  acc_result_to_op_buf,
    output logic [OUT_ADDR_W-1:0] out_buf_addr,
    output logic                  op_buffer_instr_for_sending_data,
    output logic                  instr_for_accum_to_reset,
    output logic [1:0]            state_signal,
    output logic                  i_mode,
    output logic                  busy,
    output logic                  illegal_op
);
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);
    localparam int A_LSB   = addr_lsb();
    localparam int D_LSB   = data_lsb(ADDR_W);
    localparam logic [CNT_W-1:0] DEF_LEN_M1 = CNT_W'(DEFAULT_STREAM_LEN - 1);

    logic [ENTRY_W-1:0] head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    opcode_e            op_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [DATA_W-1:0]  head_data_s;
    logic [CNT_W-1:0]   len_m1_s;

    fsm_state_e         state_r;
    fsm_state_e         state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;

    logic [ADDR_W-1:0]     inp_addr_s;
    logic [DATA_W-1:0]     inp_data_s;
    logic [ADDR_W-1:0]     wt_addr_s;
    logic [DATA_W-1:0]     wt_data_s;
    logic [OUT_ADDR_W-1:0] acc_addr_s;
    logic                  acc_res_s;
    logic [OUT_ADDR_W-1:0] out_addr_s;
    logic                  tx_s;
    logic                  acc_rst_s;
    logic [1:0]            ss_s;
    logic                  i_mode_s;
    logic                  illegal_s;

    // Opcode 0x00 is acknowledged on the handshake but never queued.
    assign instr_ready = !fifo_full_s;
    assign push_s      = instr_valid && !fifo_full_s && (instr[OPC_W-1:0] != OP_NONE);

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (instr[ENTRY_W-1:0]),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    generate
        if (INSTR_W > ENTRY_W) begin : g_pad
            logic unused_pad_s;
            assign unused_pad_s = ^instr[INSTR_W-1:ENTRY_W];
        end
    endgenerate

    assign op_s        = opcode_e'(head_s[OPC_W-1:0]);
    assign head_addr_s = head_s[A_LSB +: ADDR_W];
    assign head_data_s = head_s[D_LSB +: DATA_W];

    // Stream length minus one, substituting the default for a zero length field.
    always_comb begin
        len_m1_s = DEF_LEN_M1;
        if (head_data_s[CNT_W-1:0] == '0) begin
            len_m1_s = DEF_LEN_M1;
        end else begin
            len_m1_s = head_data_s[CNT_W-1:0] - CNT_W'(1);
        end
    end

    // Next-state, pop decision and next command outputs.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pop_s      = 1'b0;
        inp_addr_s = '0;
        inp_data_s = '0;
        wt_addr_s  = '0;
        wt_data_s  = '0;
        acc_addr_s = '0;
        acc_res_s  = 1'b0;
        out_addr_s = '0;
        tx_s       = 1'b0;
        acc_rst_s  = 1'b0;
        ss_s       = SS_IDLE;
        i_mode_s   = 1'b0;
        illegal_s  = 1'b0;

        if (state_r == ST_STREAM) begin
            if (cnt_r != '0) begin
                cnt_s    = cnt_r - CNT_W'(1);
                ss_s     = SS_STREAM;
                i_mode_s = i_mode;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            state_s = ST_IDLE;
        end

        // A finished stream hands over to the next instruction on the same edge.
        if (!fifo_empty_s && ((state_r == ST_IDLE) || (cnt_r == '0))) begin
            pop_s = 1'b1;
            case (op_s)
                OP_MAC, OP_SEND_WT: begin
                    state_s  = ST_STREAM;
                    cnt_s    = len_m1_s;
                    ss_s     = SS_STREAM;
                    i_mode_s = (op_s == OP_SEND_WT);
                end
                OP_STORE_OUT: begin
                    ss_s       = SS_WE;
                    acc_res_s  = 1'b1;
                    acc_addr_s = head_addr_s[OUT_ADDR_W-1:0];
                end
                OP_RECV_INP: begin
                    ss_s       = SS_WE;
                    inp_addr_s = head_addr_s;
                    inp_data_s = head_data_s;
                end
                OP_RECV_WT: begin
                    ss_s      = SS_WE;
                    wt_addr_s = head_addr_s;
                    wt_data_s = head_data_s;
                end
                OP_TX_OUT: begin
                    tx_s       = 1'b1;
                    out_addr_s = head_addr_s[OUT_ADDR_W-1:0];
                end
                OP_ACC_RST: acc_rst_s = 1'b1;
                OP_NOP:     illegal_s = 1'b0;
                default:    illegal_s = 1'b1;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM state and stream counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inp_buf_addr                     <= '0;
            inp_buf_data                     <= '0;
            wt_buf_addr                      <= '0;
            wt_buf_data                      <= '0;
            acc_to_op_buf_addr               <= '0;
            acc_result_to_op_buf             <= 1'b0;
            out_buf_addr                     <= '0;
            op_buffer_instr_for_sending_data <= 1'b0;
            instr_for_accum_to_reset         <= 1'b0;
            state_signal                     <= SS_IDLE;
            i_mode                           <= 1'b0;
            illegal_op                       <= 1'b0;
        end else begin
            inp_buf_addr                     <= inp_addr_s;
            inp_buf_data                     <= inp_data_s;
            wt_buf_addr                      <= wt_addr_s;
            wt_buf_data                      <= wt_data_s;
            acc_to_op_buf_addr               <= acc_addr_s;
            acc_result_to_op_buf             <= acc_res_s;
            out_buf_addr                     <= out_addr_s;
            op_buffer_instr_for_sending_data <= tx_s;
            instr_for_accum_to_reset         <= acc_rst_s;
            state_signal                     <= ss_s;
            i_mode                           <= i_mode_s;
            illegal_op                       <= illegal_s;
        end
    end

    assign busy = !fifo_empty_s || (state_r == ST_STREAM) || (state_signal != SS_IDLE)
                || acc_result_to_op_buf || op_buffer_instr_for_sending_data
                || instr_for_accum_to_reset || i_mode || illegal_op;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized bench for instr_sequencer against a queue-based cycle model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [63:0] instr;
    logic        instr_ready;
    logic [13:0] inp_buf_addr;
    logic [31:0] inp_buf_data;
    logic [13:0] wt_buf_addr;
    logic [31:0] wt_buf_data;
    logic [3:0]  acc_to_op_buf_addr;
    logic        acc_result_to_op_buf;
    logic [3:0]  out_buf_addr;
    logic        op_buffer_instr_for_sending_data;
    logic        instr_for_accum_to_reset;
    logic [1:0]  state_signal;
    logic        i_mode;
    logic        busy;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [13:0] a;
        logic [31:0] d;
    } ins_t;

    ins_t         q[$];
    int           rem = 0;
    logic         imode_m = 1'b0;
    logic [106:0] exp_v;
    logic [106:0] act_v;
    bit           acc_m;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .instr_valid                      (instr_valid),
        .instr                            (instr),
        .instr_ready                      (instr_ready),
        .inp_buf_addr                     (inp_buf_addr),
        .inp_buf_data                     (inp_buf_data),
        .wt_buf_addr                      (wt_buf_addr),
        .wt_buf_data                      (wt_buf_data),
        .acc_to_op_buf_addr               (acc_to_op_buf_addr),
        .acc_result_to_op_buf             (acc_result_to_op_buf),
        .out_buf_addr                     (out_buf_addr),
        .op_buffer_instr_for_sending_data (op_buffer_instr_for_sending_data),
        .instr_for_accum_to_reset         (instr_for_accum_to_reset),
        .state_signal                     (state_signal),
        .i_mode                           (i_mode),
        .busy                             (busy),
        .illegal_op                       (illegal_op)
    );

    assign act_v = {inp_buf_addr, inp_buf_data, wt_buf_addr, wt_buf_data, acc_to_op_buf_addr,
                    acc_result_to_op_buf, out_buf_addr, op_buffer_instr_for_sending_data,
                    instr_for_accum_to_reset, state_signal, i_mode, illegal_op};

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [13:0] a, input logic [31:0] d);
        return {13'd0, d, a, op};
    endfunction

    // Model of one clock edge: what the outputs become and how the queue changes.
    task automatic model_edge(input logic v, input logic [63:0] ins);
        logic [13:0] ia, wa;
        logic [31:0] idd, wd;
        logic [3:0]  aa, oa;
        logic        ar, tx, rs, im, il;
        logic [1:0]  ss;
        ins_t        h;
        int          len;
        ia = '0; wa = '0; idd = '0; wd = '0; aa = '0; oa = '0;
        ar = 1'b0; tx = 1'b0; rs = 1'b0; im = 1'b0; il = 1'b0; ss = 2'b00;
        acc_m = v && (q.size() < 4) && (ins[4:0] != 5'd0);
        if (rem > 0) begin
            rem--;
            ss = 2'b10;
            im = imode_m;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            case (h.op)
                5'h01, 5'h02: begin
                    len = (h.d[7:0] == 8'd0) ? 16 : int'(h.d[7:0]);
                    rem = len - 1;
                    ss = 2'b10;
                    imode_m = (h.op == 5'h02);
                    im = imode_m;
                end
                5'h03: begin ss = 2'b01; ar = 1'b1; aa = h.a[3:0]; end
                5'h04: begin ss = 2'b01; ia = h.a; idd = h.d; end
                5'h05: begin ss = 2'b01; wa = h.a; wd = h.d; end
                5'h06: begin tx = 1'b1; oa = h.a[3:0]; end
                5'h07: rs = 1'b1;
                5'h1F: ;
                default: il = 1'b1;
            endcase
        end
        if (acc_m) q.push_back('{ins[4:0], ins[18:5], ins[50:19]});
        exp_v = {ia, idd, wa, wd, aa, ar, oa, tx, rs, ss, im, il};
    endtask

    // One clock cycle: drive, check ready, step model, check outputs and busy.
    task automatic cyc(input logic v, input logic [63:0] ins, output bit accepted);
        instr_valid = v;
        instr = ins;
        checks++;
        assert (instr_ready === (q.size() < 4)) else begin
            errors++;
            $error("FAIL ready observed %0b expected %0b", instr_ready, q.size() < 4);
        end
        model_edge(v, ins);
        accepted = acc_m;
        @(posedge clk);
        #1;
        checks++;
        assert (act_v === exp_v) else begin
            errors++;
            $error("FAIL outputs observed %h expected %h", act_v, exp_v);
        end
        checks++;
        assert (busy === ((q.size() != 0) || (exp_v != '0))) else begin
            errors++;
            $error("FAIL busy observed %0b expected %0b", busy, (q.size() != 0) || (exp_v != '0));
        end
        instr_valid = 1'b0;
        instr = '0;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, a);
    endtask

    task automatic push(input logic [63:0] ins);
        bit a;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 100) begin
            cyc(1'b1, ins, a);
            tries++;
        end
        checks++;
        assert (a) else begin
            errors++;
            $error("FAIL push_timeout observed %0d expected <100", tries);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        assert (act_v === '0 && busy === 1'b0 && instr_ready === 1'b1) else begin
            errors++;
            $error("FAIL %s observed out=%h busy=%0b ready=%0b expected 0/0/1", tag, act_v, busy, instr_ready);
        end
    endtask

    logic [4:0] ops[12] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h1F, 5'h0A, 5'h08, 5'h14};

    initial begin
        logic [4:0]  op;
        logic [31:0] d;
        bit          a;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        #12;
        check_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Receive inputs: one-cycle write enable with address and data.
        push(mk(5'h04, 14'h0123, 32'hDEADBEEF));
        idle(3);

        // MAC len 5 followed by transmit from address 3.
        push(mk(5'h01, 14'h0000, 32'h0000_0005));
        push(mk(5'h06, 14'h0003, 32'h0));
        idle(8);

        // Send weights with zero length field uses the default length.
        push(mk(5'h02, 14'h1ABC, 32'hFFFF_FF00));
        idle(20);

        // Fill the queue behind a long MAC.
        push(mk(5'h01, 14'h0, 32'd20));
        push(mk(5'h03, 14'h3FF5, 32'h0));
        push(mk(5'h05, 14'h2222, 32'h1234_5678));
        push(mk(5'h1F, 14'h0, 32'h0));
        push(mk(5'h07, 14'h0, 32'h0));
        push(mk(5'h06, 14'h000C, 32'h0));
        push(mk(5'h04, 14'h0555, 32'hCAFE_F00D));
        idle(30);

        // Illegal opcode, dropped opcode 0, accumulator reset.
        push(mk(5'h0A, 14'h0, 32'h0));
        cyc(1'b1, mk(5'h00, 14'h0011, 32'h0), a);
        push(mk(5'h07, 14'h0, 32'h0));
        idle(4);

        // Reset in the middle of a stream aborts it immediately.
        push(mk(5'h01, 14'h0, 32'd10));
        idle(3);
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_mid_stream");
        q.delete();
        rem = 0;
        @(posedge clk);
        #1;
        check_reset_state("reset_held");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("after_release");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 11)];
            d = $urandom;
            if (op == 5'h01 || op == 5'h02) d[7:0] = 8'($urandom_range(0, 6));
            cyc(1'($urandom_range(0, 1)), mk(op, 14'($urandom), d), a);
        end
        idle(120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Parametrised successor to the systolic-array instruction decoder. Accepts instructions over a valid/ready handshake into an internal FIFO and decodes them one at a time. Drives the input, weight and output buffers, accumulator and MAC array with registered command pulses. Adds multi-cycle streaming commands with a per-instruction length, a busy flag and illegal-opcode reporting.

Parameters:
INSTR_W, 64, instruction width; must be >= 5+ADDR_W+DATA_W
ADDR_W, 14, buffer address field width
DATA_W, 32, data field width
OUT_ADDR_W, 4, output-buffer address width (low bits of address field)
FIFO_DEPTH, 4, instruction queue depth; power of two, >= 2
CNT_W, 8, stream-length field width (low bits of data field)
DEFAULT_STREAM_LEN, 16, stream length used when the length field is 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr  in  INSTR_W  opcode [4:0], address [ADDR_W+4:5], data [DATA_W+ADDR_W+4:ADDR_W+5]
instr_ready  out  1  FIFO can accept
inp_buf_addr  out  ADDR_W  input buffer write address
inp_buf_data  out  DATA_W  input buffer write data
wt_buf_addr  out  ADDR_W  weight buffer write address
wt_buf_data  out  DATA_W  weight buffer write data
acc_to_op_buf_addr  out  OUT_ADDR_W  output buffer destination for accumulator result
acc_result_to_op_buf  out  1  send accumulator result
out_buf_addr  out  OUT_ADDR_W  output buffer source address for transmit
op_buffer_instr_for_sending_data  out  1  transmit output
instr_for_accum_to_reset  out  1  accumulator reset
state_signal  out  2  01 write enable, 10 streaming, 00 idle
i_mode  out  1  MAC takes weights from the weight buffer
busy  out  1  work pending or in progress
illegal_op  out  1  one-cycle pulse for an undefined opcode

Behaviour:
- Reset (asynchronous, immediate): all outputs 0 except instr_ready=1. FIFO emptied, FSM to IDLE, stream counter cleared. A reset mid-stream aborts the stream; no further pulses.
- Push when instr_valid && instr_ready. Opcode 0x00 is accepted but not enqueued. instr_ready = !full; there is no lookahead, so ready stays low while full even if a pop occurs in the same cycle.
- Opcodes: 0x01 MAC (stream), 0x02 send weights (stream, i_mode=1), 0x03 store output, 0x04 receive inputs, 0x05 receive weights, 0x06 transmit output, 0x07 reset accumulator, 0x1F NOP. All others are illegal.
- All command outputs are registered. Every output is 0 in any cycle that has no command driving it.
- FSM IDLE: if the FIFO is non-empty, pop the head and decode it.
  - Single-cycle ops (0x03–0x07, NOP, illegal): outputs are asserted for exactly one cycle; FSM stays IDLE. Back-to-back pops give one instruction per cycle.
  - Stream ops: go to STREAM.
- 0x03: state_signal=01, acc_result_to_op_buf=1, acc_to_op_buf_addr=address[OUT_ADDR_W-1:0].
- 0x04 / 0x05: state_signal=01; inp_/wt_buf_addr=address, inp_/wt_buf_data=data.
- 0x06: op_buffer_instr_for_sending_data=1, out_buf_addr=address[OUT_ADDR_W-1:0].
- 0x07: instr_for_accum_to_reset=1.
- NOP: no outputs; consumes one cycle.
- Illegal opcode: illegal_op=1 only.
- STREAM state:
  - len = data[CNT_W-1:0]; if 0, len = DEFAULT_STREAM_LEN.
  - state_signal=10 (and i_mode=1 for 0x02) is held for exactly len consecutive cycles.
  - The counter loads len-1 at the pop and decrements each cycle.
  - At count 0 the FSM returns to IDLE and may pop the next instruction on the same edge, so there is no bubble.
  - Pushes are still accepted during STREAM.
- Latency: an instruction accepted at edge k into an empty FIFO while IDLE is popped at edge k+1, and its outputs are valid in the cycle after edge k+1.
- busy = FIFO non-empty || FSM==STREAM || any command output currently asserted.

Decomposition:
- Package ctrl_pkg:
  - opcode enum (OP_NONE, OP_MAC, OP_SEND_WT, OP_STORE_OUT, OP_RECV_INP, OP_RECV_WT, OP_TX_OUT, OP_ACC_RST, OP_NOP)
  - state_signal constants (SS_IDLE=00, SS_WE=01, SS_STREAM=10)
  - field-offset helper functions
  - FSM state enum
- Sub-module: instr_fifo (synchronous FIFO, parametrised WIDTH and DEPTH, full/empty flags).

Test Plan:
- Reset mid-stream: after 3 cycles of a MAC len 10, pull rst_n low -> all outputs 0 immediately, busy=0, instr_ready=1.
- Single push of 0x04, address 0x0123, data 0xDEADBEEF, at edge k -> at edge k+1: state_signal=01, inp_buf_addr=0x0123, inp_buf_data=0xDEADBEEF for one cycle, then all 0.
- Push MAC with len 5, then 0x06 with address 3 -> state_signal=10 for exactly 5 cycles; out_buf_addr=3 and op_buffer_instr_for_sending_data=1 in the very next cycle.
- Send weights with len field 0 -> state_signal=10 and i_mode=1 for exactly 16 cycles.
- Hold instr_valid=1 with 6 pushes during a MAC of len 20 (FIFO_DEPTH=4) -> instr_ready falls after the 4th accept; all 6 instructions execute in order.
- Opcode 0x0A, then 0x00, then 0x07 -> illegal_op pulses once; 0x00 produces nothing; instr_for_accum_to_reset pulses once.
